// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Sequencer states of the memory port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2,
    RDONE  = 2'd3
  } arb_state_t;

  // Master indices
  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

  // Read latency counter width; covers RD_LAT up to 3
  localparam int LAT_W = 2;

  // One-hot strobe vector {m1, m0} for a master index
  function automatic logic [1:0] master_onehot(input logic idx);
    master_onehot = (idx == M_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker: round-robin on last winner, or fixed priority to master 0 with ARB_FIXED_PRIO_EN.
// Latency: purely combinational.
// Backpressure: none; the caller only consults it while able to issue.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);
  import mem_arb_pkg::*;

`ifdef ARB_FIXED_PRIO_EN
  // last is irrelevant when master 0 always wins ties
  logic unused_last;
  assign unused_last = last;

  // Master 0 wins whenever it asks
  always_comb begin
    valid  = req0 | req1;
    winner = req0 ? M_CORE : M_DMA;
  end
`else
  // Lone requester wins; on a tie the master that did not win last time goes
  always_comb begin
    valid  = req0 | req1;
    winner = M_CORE;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = M_DMA;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous memory port between the core (master 0) and DMA (master 1); ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: req->gnt 1 cycle from idle; gnt->rvalid RD_LAT+1 cycles; write 2 cycles, read RD_LAT+3 cycles.
// Backpressure: masters hold req until their gnt pulse; requests outside IDLE are ignored, not queued.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          w0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          w1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_w,
  input  logic [DW-1:0] mem_din
);

  localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);

  arb_state_t       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             last;
  logic             cur;

  logic             arb_vld;
  logic             arb_win;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_w;
  logic [1:0]       win_oh;

  arb_rr2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (arb_vld),
    .winner (arb_win)
  );

  // Steer the winning master's access fields toward the memory registers
  always_comb begin
    sel_addr  = (arb_win == M_DMA) ? addr1  : addr0;
    sel_wdata = (arb_win == M_DMA) ? wdata1 : wdata0;
    sel_w     = (arb_win == M_DMA) ? w1     : w0;
    win_oh    = master_onehot(arb_win);
  end

  // Access sequencer: registered memory port, grant and read-return strobes
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      last     <= 1'b1;
      cur      <= M_CORE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_w    <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            // Access fields are captured here only; later changes are ignored
            mem_addr <= sel_addr;
            mem_dout <= sel_wdata;
            mem_w    <= sel_w;
            gnt0     <= win_oh[0];
            gnt1     <= win_oh[1];
            last     <= arb_win;
            cur      <= arb_win;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // A write strobe lasts exactly this one cycle
          mem_w <= 1'b0;
          if (mem_w) begin
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_W'(1);
            state   <= RWAIT;
          end
        end
        RWAIT: begin
          // mem_addr stays put until the memory has produced the word
          if (lat_cnt == RD_LAT_C) begin
            rdata   <= mem_din;
            rvalid0 <= (cur == M_CORE);
            rvalid1 <= (cur == M_DMA);
            state   <= RDONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_bus_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instance A (RD_LAT=1)
  logic        Resetn, req0, w0, req1, w1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1, mem_w;
  logic [15:0] rdata, mem_addr, mem_dout, mem_din;

  // Instance B (RD_LAT=3)
  logic        resetn_b, req0_b, w0_b, req1_b, w1_b;
  logic [15:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
  logic        gnt0_b, rvalid0_b, gnt1_b, rvalid1_b, mem_w_b;
  logic [15:0] rdata_b, mem_addr_b, mem_dout_b, mem_din_b;
  logic [15:0] pipe1_b, pipe2_b;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_a (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .w0(w0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .w1(w1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_w(mem_w), .mem_din(mem_din)
  );

  mem_bus_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_b (
    .Clock(Clock), .Resetn(resetn_b),
    .req0(req0_b), .w0(w0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1_b), .w1(w1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b), .mem_w(mem_w_b), .mem_din(mem_din_b)
  );

  // Memory contents: one fixed word, otherwise an address pattern
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Synchronous memories with 1 and 3 cycles of read latency
  always @(posedge Clock) begin
    mem_din   <= mem_f(mem_addr);
    pipe1_b   <= mem_f(mem_addr_b);
    pipe2_b   <= pipe1_b;
    mem_din_b <= pipe2_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic e0, e1;
    Resetn = 1'b0; req0 = 1'b0; w0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; w1 = 1'b0; addr1 = '0; wdata1 = '0;
    resetn_b = 1'b0; req0_b = 1'b0; w0_b = 1'b0; addr0_b = '0; wdata0_b = '0;
    req1_b = 1'b0; w1_b = 1'b0; addr1_b = '0; wdata1_b = '0;

    // 1. Reset then idle
    tick(); tick();
    chk("rst_gnt",    32'({gnt0, gnt1}), 32'h0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
    chk("rst_mem_w",  32'(mem_w), 32'h0);
    chk("rst_addr",   32'(mem_addr), 32'h0);
    chk("rst_dout",   32'(mem_dout), 32'h0);
    chk("rst_rdata",  32'(rdata), 32'h0);
    chk("rst_state",  32'(u_a.state), 32'h0);
    chk("rst_last",   32'(u_a.last), 32'h1);
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt", 32'({gnt0, gnt1}), 32'h0);
    end

    // 2. Single read by master 0
    req0 = 1'b1; w0 = 1'b0; addr0 = 16'h0010;
    tick();
    chk("rd_gnt0",  32'(gnt0), 32'h1);
    chk("rd_gnt1",  32'(gnt1), 32'h0);
    chk("rd_addr",  32'(mem_addr), 32'h0010);
    chk("rd_mem_w", 32'(mem_w), 32'h0);
    req0 = 1'b0; addr0 = 16'hFFFF;
    tick();
    chk("rd_gnt0_drop", 32'(gnt0), 32'h0);
    chk("rd_early_rv",  32'(rvalid0), 32'h0);
    chk("rd_addr_hold", 32'(mem_addr), 32'h0010);
    tick();
    chk("rd_rvalid0", 32'(rvalid0), 32'h1);
    chk("rd_rvalid1", 32'(rvalid1), 32'h0);
    chk("rd_rdata",   32'(rdata), 32'hBEEF);
    tick();
    chk("rd_rv_drop",   32'(rvalid0), 32'h0);
    chk("rd_data_hold", 32'(rdata), 32'hBEEF);

    // 3. Single write by master 1
    req1 = 1'b1; w1 = 1'b1; addr1 = 16'h1000; wdata1 = 16'h00A5;
    tick();
    chk("wr_gnt1",  32'(gnt1), 32'h1);
    chk("wr_gnt0",  32'(gnt0), 32'h0);
    chk("wr_mem_w", 32'(mem_w), 32'h1);
    chk("wr_addr",  32'(mem_addr), 32'h1000);
    chk("wr_dout",  32'(mem_dout), 32'h00A5);
    req1 = 1'b0;
    tick();
    chk("wr_mem_w_drop", 32'(mem_w), 32'h0);
    chk("wr_gnt1_drop",  32'(gnt1), 32'h0);
    chk("wr_idle",       32'(u_a.state), 32'h0);
    chk("wr_no_rvalid",  32'({rvalid0, rvalid1}), 32'h0);

    // 4/5. Contention, both writing, both held high from reset release
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    req0 = 1'b1; w0 = 1'b1; addr0 = 16'hA000; wdata0 = 16'h0001;
    req1 = 1'b1; w1 = 1'b1; addr1 = 16'hB000; wdata1 = 16'h0002;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e0 = (k % 2 == 1) && (FIXED || (((k - 1) / 2) % 2 == 0));
      e1 = (k % 2 == 1) && !e0;
      chk("cont_gnt0", 32'(gnt0), 32'(e0));
      chk("cont_gnt1", 32'(gnt1), 32'(e1));
      chk("cont_both", 32'(gnt0 & gnt1), 32'h0);
      if (k % 2 == 1) chk("cont_addr", 32'(mem_addr), e0 ? 32'hA000 : 32'hB000);
    end
    req0 = 1'b0;
    tick();
    chk("cont_tail_gnt1", 32'(gnt1), 32'h1);
    chk("cont_tail_gnt0", 32'(gnt0), 32'h0);
    chk("cont_tail_addr", 32'(mem_addr), 32'hB000);
    req1 = 1'b0;
    tick(); tick();

    // 6. Reset during a read wait, RD_LAT=3
    resetn_b = 1'b1;
    req0_b = 1'b1; w0_b = 1'b0; addr0_b = 16'h0010;
    tick();
    chk("rw3_gnt0", 32'(gnt0_b), 32'h1);
    req0_b = 1'b0;
    tick();
    chk("rw3_in_wait", 32'(u_b.state), 32'h2);
    resetn_b = 1'b0;
    tick();
    chk("rw3_rst_state", 32'(u_b.state), 32'h0);
    chk("rw3_rst_rdata", 32'(rdata_b), 32'h0);
    chk("rw3_rst_rv",    32'(rvalid0_b), 32'h0);
    resetn_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw3_dropped_rv", 32'({rvalid0_b, rvalid1_b}), 32'h0);
    end
    req1_b = 1'b1; w1_b = 1'b0; addr1_b = 16'h0020;
    tick();
    chk("rw3_gnt1", 32'(gnt1_b), 32'h1);
    chk("rw3_addr", 32'(mem_addr_b), 32'h0020);
    req1_b = 1'b0;
    tick(); tick(); tick();
    chk("rw3_early_rv", 32'(rvalid1_b), 32'h0);
    tick();
    chk("rw3_rvalid1", 32'(rvalid1_b), 32'h1);
    chk("rw3_rvalid0", 32'(rvalid0_b), 32'h0);
    chk("rw3_rdata",   32'(rdata_b), 32'h5A7A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
